// File: rtl/rom_bus_interface_pkg.sv
// Shared definitions for the 4001 ROM bus interface: FSM state encodings,
// bus widths and the chip-select compare helper.
package rom_bus_interface_pkg;

  localparam int NIBBLE  = 4;   // data bus width
  localparam int BYTE_W  = 8;   // ROM word width
  localparam int CNT_W   = 4;   // ROM latency counter width (1..16 cycles)

  // Strobe slots in the edge-detector array
  localparam int NUM_STB  = 4;
  localparam int STB_SYNC = 0;
  localparam int STB_A1   = 1;
  localparam int STB_A2   = 2;
  localparam int STB_A3   = 3;

  typedef enum logic [3:0] {
    ST_SYNC_WAIT = 4'd0,
    ST_IDLE      = 4'd1,
    ST_ADDR_LO   = 4'd2,
    ST_ADDR_MID  = 4'd3,
    ST_FETCH     = 4'd4,
    ST_READY     = 4'd5,
    ST_DRIVE_M1  = 4'd6,
    ST_DRIVE_M2  = 4'd7,
    ST_SKIP      = 4'd8
  } rbi_state_e;

  // Chip number in A3 must equal the strapped CHIP_ID for this ROM to respond
  function automatic logic nib_match(input logic [NIBBLE-1:0] a,
                                     input logic [NIBBLE-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/rom_bus_interface_phase_edge.sv
// Single-bit rising-edge detector for a level phase strobe. Clearing the
// history makes a strobe already high when clear drops count as a new rise.
module phase_edge (
  input  logic sysclk,
  input  logic clr,
  input  logic strobe,
  output logic rise
);

  logic prev;

  // Remember last cycle's strobe level
  always_ff @(posedge sysclk) begin
    if (clr) prev <= 1'b0;
    else     prev <= strobe;
  end

  assign rise = strobe & ~prev & ~clr;

endmodule

// File: rtl/rom_bus_interface.sv
// 4001 ROM bus interface: latches the 12-bit address over A1..A3, selects on
// the chip nibble, fetches one byte from local ROM storage and drives the
// OPR/OPA nibbles back onto the data bus during M1/M2.
module rom_bus_interface
  import rom_bus_interface_pkg::*;
#(
  parameter logic [3:0] CHIP_ID     = 4'h0,
  parameter int         ROM_LATENCY = 1
) (
  input  logic              sysclk,
  input  logic              poc,
  input  logic              sync,
  input  logic              a12,
  input  logic              a22,
  input  logic              a32,
  input  logic              m11,
  input  logic              m12,
  input  logic              m21,
  input  logic              m22,
  input  logic [NIBBLE-1:0] data_in,
  output logic [NIBBLE-1:0] data_out,
  output logic              data_oe,
  output logic [BYTE_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [BYTE_W-1:0] rom_data,
  output logic              selected
);

  if (ROM_LATENCY < 1 || ROM_LATENCY > 16) begin : g_bad_latency
    $error("rom_bus_interface: ROM_LATENCY must be within 1..16");
  end

  // Counter is loaded with latency-1 and held during the rom_rd cycle, so
  // capture lands exactly ROM_LATENCY cycles after the read strobe.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ROM_LATENCY - 1);

  logic [NUM_STB-1:0] stb_lvl;
  logic [NUM_STB-1:0] stb_rise;

  assign stb_lvl[STB_SYNC] = sync;
  assign stb_lvl[STB_A1]   = a12;
  assign stb_lvl[STB_A2]   = a22;
  assign stb_lvl[STB_A3]   = a32;

  for (genvar i = 0; i < NUM_STB; i++) begin : g_edge
    phase_edge u_edge (
      .sysclk (sysclk),
      .clr    (poc),
      .strobe (stb_lvl[i]),
      .rise   (stb_rise[i])
    );
  end

  logic sync_r, a1_r, a2_r, a3_r;
  assign sync_r = stb_rise[STB_SYNC];
  assign a1_r   = stb_rise[STB_A1];
  assign a2_r   = stb_rise[STB_A2];
  assign a3_r   = stb_rise[STB_A3];

  logic m1_lvl, m2_lvl;
  assign m1_lvl = m11 | m12;
  assign m2_lvl = m21 | m22;

  rbi_state_e        state;
  logic [BYTE_W-1:0] addr_lo;   // A1/A2 nibbles; chip nibble is consumed at the A3 edge
  logic [BYTE_W-1:0] byte_q;
  logic [CNT_W-1:0]  lat_cnt;

  // Any address strobe arriving outside its own slot means we lost cycle
  // alignment; ignore them entirely while already waiting for sync.
  logic bad_strobe;
  always_comb begin
    bad_strobe = 1'b0;
    if (state != ST_SYNC_WAIT) begin
      bad_strobe = (a1_r && state != ST_IDLE)     ||
                   (a2_r && state != ST_ADDR_LO)  ||
                   (a3_r && state != ST_ADDR_MID);
    end
  end

  // Instruction-cycle sequencer with registered bus outputs
  always_ff @(posedge sysclk) begin
    if (poc) begin
      state    <= ST_SYNC_WAIT;
      data_out <= '0;
      data_oe  <= 1'b0;
      rom_addr <= '0;
      rom_rd   <= 1'b0;
      selected <= 1'b0;
      byte_q   <= '0;
      addr_lo  <= '0;
      lat_cnt  <= '0;
    end else begin
      rom_rd <= 1'b0;
      if (sync_r) begin
        // X3 marks the start of a fresh cycle from any state
        state    <= ST_IDLE;
        data_oe  <= 1'b0;
        selected <= 1'b0;
      end else if (bad_strobe) begin
        state    <= ST_SYNC_WAIT;
        data_oe  <= 1'b0;
        selected <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (a1_r) begin
              addr_lo[3:0] <= data_in;
              state        <= ST_ADDR_LO;
            end
          end
          ST_ADDR_LO: begin
            if (a2_r) begin
              addr_lo[7:4] <= data_in;
              state        <= ST_ADDR_MID;
            end
          end
          ST_ADDR_MID: begin
            if (a3_r) begin
              if (nib_match(data_in, CHIP_ID)) begin
                selected <= 1'b1;
                rom_addr <= addr_lo;
                rom_rd   <= 1'b1;
                lat_cnt  <= LAT_LOAD;
                state    <= ST_FETCH;
              end else begin
                selected <= 1'b0;
                state    <= ST_SKIP;
              end
            end
          end
          ST_FETCH: begin
            if (!rom_rd) begin
              if (lat_cnt == '0) begin
                byte_q <= rom_data;
                state  <= ST_READY;
              end else begin
                lat_cnt <= lat_cnt - 1'b1;
              end
            end
          end
          ST_READY: begin
            if (m1_lvl) begin
              data_out <= byte_q[7:4];
              data_oe  <= 1'b1;
              state    <= ST_DRIVE_M1;
            end
          end
          ST_DRIVE_M1: begin
            if (m2_lvl) begin
              data_out <= byte_q[3:0];
              data_oe  <= 1'b1;
              state    <= ST_DRIVE_M2;
            end else begin
              data_oe <= m1_lvl;
            end
          end
          ST_DRIVE_M2: begin
            data_oe <= m2_lvl;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_bus_interface.sv
// Directed bench: two ROM interfaces (latency 1 and 16, both CHIP_ID=3) share
// one generated 8-subcycle bus; each has its own delayed ROM storage model.
module tb_rom_bus_interface;

  localparam int SUB  = 48;          // sysclks per subcycle
  localparam int HALF = SUB / 2;     // clk1 half, then clk2 half

  logic       sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic       poc, sync, a12, a22, a32, m11, m12, m21, m22;
  logic [3:0] data_in;
  logic [7:0] rom_byte;

  logic [3:0]  dout_a, dout_b;
  logic        oe_a, oe_b, rd_a, rd_b, sel_a, sel_b;
  logic [7:0]  ra_a, ra_b, rdat_a, rdat_b;
  logic [15:0] dly_a, dly_b;

  int nchk = 0;
  int nerr = 0;

  // ROM storage model: byte appears exactly ROM_LATENCY cycles after rom_rd
  always @(posedge sysclk) begin
    if (poc) begin
      dly_a <= '0;
      dly_b <= '0;
    end else begin
      dly_a <= {dly_a[14:0], rd_a};
      dly_b <= {dly_b[14:0], rd_b};
    end
  end
  assign rdat_a = dly_a[0]  ? rom_byte : 8'h00;
  assign rdat_b = dly_b[15] ? rom_byte : 8'h00;

  rom_bus_interface #(.CHIP_ID(4'h3), .ROM_LATENCY(1)) dut_a (
    .sysclk(sysclk), .poc(poc), .sync(sync), .a12(a12), .a22(a22), .a32(a32),
    .m11(m11), .m12(m12), .m21(m21), .m22(m22), .data_in(data_in),
    .data_out(dout_a), .data_oe(oe_a), .rom_addr(ra_a), .rom_rd(rd_a),
    .rom_data(rdat_a), .selected(sel_a));

  rom_bus_interface #(.CHIP_ID(4'h3), .ROM_LATENCY(16)) dut_b (
    .sysclk(sysclk), .poc(poc), .sync(sync), .a12(a12), .a22(a22), .a32(a32),
    .m11(m11), .m12(m12), .m21(m21), .m22(m22), .data_in(data_in),
    .data_out(dout_b), .data_oe(oe_b), .rom_addr(ra_b), .rom_rd(rd_b),
    .rom_data(rdat_b), .selected(sel_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_strobes();
    sync = 0; a12 = 0; a22 = 0; a32 = 0;
    m11 = 0; m12 = 0; m21 = 0; m22 = 0;
    data_in = 4'h0;
  endtask

  // One instruction cycle A1 A2 A3 M1 M2 X1 X2 X3(sync). Outputs are sampled
  // on the falling edge, after the rising edge that saw the step's inputs.
  task automatic run_cycle(input string tag,
                           input logic [3:0] n1, input logic [3:0] n2, input logic [3:0] n3,
                           input bit a2_as_a32, input int poc_at,
                           input int exp_rd, input bit exp_sel);
    int  rd_na = 0, rd_nb = 0;
    int  bad_oe_a = 0, bad_oe_b = 0, bad_do_a = 0, bad_do_b = 0;
    bit  sel_live;
    sel_live = exp_sel;
    for (int sc = 0; sc < 8; sc++) begin
      for (int k = 0; k < SUB; k++) begin
        int         t;
        bit         ph2, exp_oe;
        logic [3:0] exp_nib;
        t   = sc * SUB + k;
        ph2 = (k >= HALF);
        data_in = (sc == 0) ? n1 : (sc == 1) ? n2 : (sc == 2) ? n3 : 4'h0;
        a12  = (sc == 0) && ph2;
        a22  = (sc == 1) && ph2 && !a2_as_a32;
        a32  = ((sc == 2) && ph2) || ((sc == 1) && ph2 && a2_as_a32);
        m11  = (sc == 3) && !ph2;
        m12  = (sc == 3) && ph2;
        m21  = (sc == 4) && !ph2;
        m22  = (sc == 4) && ph2;
        sync = (sc == 7);
        poc  = (t == poc_at);
        if (t == poc_at) sel_live = 0;
        @(negedge sysclk);
        if (rd_a) rd_na++;
        if (rd_b) rd_nb++;
        exp_oe  = sel_live && (sc == 3 || sc == 4);
        exp_nib = (sc == 3) ? rom_byte[7:4] : rom_byte[3:0];
        if (oe_a !== exp_oe) bad_oe_a++;
        if (oe_b !== exp_oe) bad_oe_b++;
        if (exp_oe && dout_a !== exp_nib) bad_do_a++;
        if (exp_oe && dout_b !== exp_nib) bad_do_b++;
        if (sc == 5 && k == 0) begin
          chk({tag, " sel_a"}, 32'(sel_a), 32'(sel_live));
          chk({tag, " sel_b"}, 32'(sel_b), 32'(sel_live));
        end
      end
    end
    poc = 0;
    idle_strobes();
    chk({tag, " rd_pulses_a"}, rd_na, exp_rd);
    chk({tag, " rd_pulses_b"}, rd_nb, exp_rd);
    chk({tag, " oe_window_a"}, bad_oe_a, 0);
    chk({tag, " oe_window_b"}, bad_oe_b, 0);
    chk({tag, " data_out_a"}, bad_do_a, 0);
    chk({tag, " data_out_b"}, bad_do_b, 0);
  endtask

  initial begin
    idle_strobes();
    rom_byte = 8'h00;
    poc = 1;
    repeat (3) @(negedge sysclk);
    chk("reset data_oe",   32'({oe_a, oe_b}), 0);
    chk("reset rom_rd",    32'({rd_a, rd_b}), 0);
    chk("reset selected",  32'({sel_a, sel_b}), 0);
    chk("reset rom_addr",  32'({ra_a, ra_b}), 0);
    chk("reset data_out",  32'({dout_a, dout_b}), 0);
    poc = 0;
    repeat (4) @(negedge sysclk);

    // Address strobes before any sync are ignored
    rom_byte = 8'hC7;
    run_cycle("t1_nosync", 4'h5, 4'hA, 4'h3, 0, -1, 0, 0);
    chk("t1 rom_addr_a", 32'(ra_a), 32'h00);

    // Matching cycle: A5 fetched, C then 7 driven
    run_cycle("t2_match", 4'h5, 4'hA, 4'h3, 0, -1, 1, 1);
    chk("t2 rom_addr_a", 32'(ra_a), 32'hA5);
    chk("t2 rom_addr_b", 32'(ra_b), 32'hA5);

    // Chip mismatch: no fetch, no drive, rom_addr holds
    run_cycle("t3_miss", 4'h5, 4'hA, 4'h4, 0, -1, 0, 0);
    chk("t3 rom_addr_hold", 32'(ra_a), 32'hA5);
    rom_byte = 8'h3E;
    run_cycle("t3_next", 4'hC, 4'h3, 4'h3, 0, -1, 1, 1);
    chk("t3 rom_addr_next", 32'(ra_b), 32'h3C);

    // poc five sysclks into M1: drive drops next edge, rom_addr cleared
    rom_byte = 8'h96;
    run_cycle("t5_poc", 4'h1, 4'h2, 4'h3, 0, 3 * SUB + 5, 1, 1);
    chk("t5 rom_addr_clr", 32'(ra_a), 32'h00);
    rom_byte = 8'h5A;
    run_cycle("t5_after", 4'h7, 4'h8, 4'h3, 0, -1, 1, 1);
    chk("t5 rom_addr_after", 32'(ra_a), 32'h87);

    // a32 while in ADDR_LO aborts; next cycle after sync recovers
    run_cycle("t6_abort", 4'h1, 4'h2, 4'h3, 1, -1, 0, 0);
    chk("t6 rom_addr_hold", 32'(ra_a), 32'h87);
    rom_byte = 8'hE1;
    run_cycle("t6_recover", 4'hF, 4'hF, 4'h3, 0, -1, 1, 1);
    chk("t6 rom_addr_a", 32'(ra_a), 32'hFF);
    chk("t6 rom_addr_b", 32'(ra_b), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
